// File: rtl/riscv_trace_pkg.sv
// Shared types and sizing for the register write-back trace path.
// Entries carry a wrapping 16-bit sequence number so downstream can detect drops.
package riscv_trace_pkg;

  localparam int SEQ_W         = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [4:0]       reg_num;
    logic [31:0]      reg_data;
  } trace_entry_t;

endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock FIFO of trace entries; head is visible the cycle after the push edge.
// Pushes beyond capacity are ignored unless a pop frees the slot in the same cycle.
module trace_sync_fifo
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  trace_entry_t           push_entry,
  input  logic                   pop,
  output trace_entry_t           head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;
  trace_entry_t mem [DEPTH];

  // Extra MSB distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is deliberately unreset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures core register write-backs as sequenced trace entries; 1-cycle push-to-output.
// trace_valid/trace_ready handshake; events arriving while full are dropped and counted.
module wb_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_reg_num,
  input  logic [31:0]            wb_reg_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [SEQ_W-1:0]       trace_seq,
  output logic [4:0]             trace_reg_num,
  output logic [31:0]            trace_reg_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [SEQ_W-1:0]       overflow_count
);

  logic         is_event;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [SEQ_W-1:0] seq_cnt;
  trace_entry_t push_entry;
  trace_entry_t head;

  assign is_event    = wb_valid && !(FILTER_X0 && (wb_reg_num == 5'd0));
  assign trace_valid = !empty;
  assign pop         = trace_valid && trace_ready;
  assign push        = is_event && (!full || pop);
  assign push_entry  = '{seq: seq_cnt, reg_num: wb_reg_num, reg_data: wb_reg_data};

  // Dropped events still consume a sequence number so the gap shows downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_cnt        <= '0;
      overflow_count <= '0;
    end else begin
      if (is_event) seq_cnt <= seq_cnt + 1'b1;
      if (is_event && !push && (overflow_count != '1))
        overflow_count <= overflow_count + 1'b1;
    end
  end

  trace_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .level      (level)
  );

  assign trace_seq      = head.seq;
  assign trace_reg_num  = head.reg_num;
  assign trace_reg_data = head.reg_data;

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, setting FIFO entries; a power of two >= 2.
REQ-002 The block SHALL have parameter FILTER_X0, default 1; when 1, writes to register 0 are discarded.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wb_valid, input, 1 bit: a core register write-back occurs this cycle.
REQ-006 The block SHALL have port wb_reg_num, input, 5 bits: destination register index.
REQ-007 The block SHALL have port wb_reg_data, input, 32 bits: value written.
REQ-008 The block SHALL have port trace_valid, output, 1 bit: the head entry is presented.
REQ-009 The block SHALL have port trace_ready, input, 1 bit: the consumer accepts the head entry.
REQ-010 The block SHALL have port trace_seq, output, 16 bits: sequence number of the head entry.
REQ-011 The block SHALL have port trace_reg_num, output, 5 bits: register index of the head entry.
REQ-012 The block SHALL have port trace_reg_data, output, 32 bits: data of the head entry.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have port overflow_count, output, 16 bits: number of dropped events, saturating.

Function
REQ-015 An event SHALL be a cycle with wb_valid=1, excluding wb_reg_num=0 when FILTER_X0=1.
REQ-016 Each event SHALL receive the current value of a 16-bit sequence counter, which then increments, wrapping from 0xFFFF to 0x0000.
REQ-017 An event SHALL be pushed when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-018 An event that cannot be pushed SHALL be dropped, and overflow_count SHALL increment, saturating at 0xFFFF; its sequence number is still consumed, so the gap is visible downstream.
REQ-019 A pop SHALL occur exactly when trace_valid=1 and trace_ready=1.
REQ-020 trace_valid SHALL be equivalent to level!=0.
REQ-021 An event pushed at edge N into an empty buffer SHALL appear on the trace_* outputs after edge N; push-to-output latency is 1 cycle.
REQ-022 While trace_valid=1 and trace_ready=0, trace_seq, trace_reg_num and trace_reg_data SHALL hold stable.
REQ-023 Entries SHALL leave in push order.
REQ-024 A simultaneous push and pop SHALL leave level unchanged.
REQ-025 A pop when empty is impossible by REQ-019; trace_ready while empty SHALL have no effect.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap naturally; full is indicated by equal indices with differing MSBs.

Reset
REQ-027 Asserting reset (low) at any time, including mid-stream, SHALL immediately clear pointers, level, the sequence counter and overflow_count; trace_valid then reads 0.
REQ-028 Storage contents SHALL need no reset; after reset, trace_seq, trace_reg_num and trace_reg_data are don't-care while trace_valid=0.
REQ-029 The first event after reset deassertion SHALL carry sequence number 0.

Structure
REQ-030 Package riscv_trace_pkg SHALL hold typedef trace_entry_t {seq[15:0], reg_num[4:0], reg_data[31:0]}, the sequence width constant (16), and the default DEPTH.
REQ-031 Storage and pointers SHALL be one sub-module, trace_sync_fifo, which carries trace_entry_t.
REQ-032 wb_trace_buffer SHALL own filtering, sequence numbering and overflow accounting.

Verification
REQ-033 Reset, then drive 3 writes x5=0x11, x6=0x22, x7=0x33 with trace_ready=1 -> outputs show seq 0,1,2 in order, each 1 cycle after its write, and level returns to 0.
REQ-034 With FILTER_X0=1, drive x0=0xDEAD and then x1=0x1 -> only x1 is emitted, with seq=0.
REQ-035 With DEPTH=8 and trace_ready=0, drive 10 writes -> level=8, overflow_count=2; draining yields seq 0..7; the next event gets seq 10.
REQ-036 When full, drive a push and a pop in the same cycle -> level stays 8, overflow_count is unchanged, and the new entry is stored.
REQ-037 Preload the sequence counter near 0xFFFE and send 3 events -> seq 0xFFFE, 0xFFFF, 0x0000.
REQ-038 Assert reset mid-stream with level=5 -> trace_valid=0 and overflow_count=0 immediately, and the next event carries seq 0.
